// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: receive-side frame controller behind a UART receiver.
// Hunts for HEADER, buffers one frame (HEADER, LEN, LEN payload bytes, CHK),
// verifies the XOR checksum and replays the payload on a valid/ready stream.
// Optional feature macro: UART_FRAME_TIMEOUT_EN enables the inter-byte
// timeout counter and to_err; without it to_err is tied low.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] HEADER         = 8'hAA,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        chk_err,
    output logic        len_err,
    output logic        to_err,
    output logic        ovr_err,
    output logic [15:0] frame_cnt
);

    localparam int IDX_W = $clog2(MAX_LEN + 1);
    localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DEPTH = 1 << AW;
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LENGTH,
        S_PAYLOAD,
        S_CHECK,
        S_DRAIN
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] len_q;
    logic [7:0]       xor_q;
    logic             out_valid_q;
    logic [7:0]       out_data_q;
    logic             out_last_q;
    logic             chk_err_q;
    logic             len_err_q;
    logic             ovr_err_q;
    logic [15:0]      frame_cnt_q;
    logic [7:0]       mem_q [DEPTH];

    logic [IDX_W-1:0] idx_inc_d;
    logic [IDX_W-1:0] len_m1_d;
    logic [AW-1:0]    rd_addr_d;
    logic [7:0]       rd_data_d;
    logic             to_expire_d;

    // Buffer read address: slot 0 when entering DRAIN, next slot while draining.
    always_comb begin
        idx_inc_d = idx_q + IDX_ONE;
        len_m1_d  = len_q - IDX_ONE;
        rd_addr_d = (state_q == S_DRAIN) ? AW'(idx_inc_d) : '0;
        rd_data_d = mem_q[rd_addr_d];
    end

    // Payload buffer; contents survive reset and are only written in PAYLOAD.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_PAYLOAD && byte_valid) begin
            mem_q[idx_q[AW-1:0]] <= byte_data;
        end
    end

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            to_err_q;
    logic            to_active_d;

    // Expiry only when the counter is full and no byte arrives this cycle.
    always_comb begin
        to_active_d = (state_q == S_LENGTH) || (state_q == S_PAYLOAD) ||
                      (state_q == S_CHECK);
        to_expire_d = to_active_d && !byte_valid && (to_cnt_q == TO_LAST);
    end

    // Inter-byte counter: cleared outside the frame body and on every byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_err_q <= to_expire_d;
            if (!to_active_d || byte_valid || to_expire_d) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
        end
    end

    assign to_err = to_err_q;
`else
    assign to_expire_d = 1'b0;
    assign to_err      = 1'b0;
`endif

    // Frame FSM with registered stream outputs, error pulses and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HUNT;
            idx_q       <= '0;
            len_q       <= '0;
            xor_q       <= 8'h00;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            chk_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            ovr_err_q   <= 1'b0;
            frame_cnt_q <= 16'h0000;
        end else begin
            chk_err_q <= 1'b0;
            len_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
            case (state_q)
                S_HUNT: begin
                    if (byte_valid && byte_data == HEADER) begin
                        state_q <= S_LENGTH;
                    end
                end
                S_LENGTH: begin
                    if (byte_valid) begin
                        if (byte_data != 8'h00 && byte_data <= MAX_LEN_B) begin
                            len_q   <= byte_data[IDX_W-1:0];
                            xor_q   <= byte_data;
                            idx_q   <= '0;
                            state_q <= S_PAYLOAD;
                        end else begin
                            len_err_q <= 1'b1;
                            state_q   <= S_HUNT;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (byte_valid) begin
                        xor_q <= xor_q ^ byte_data;
                        idx_q <= idx_inc_d;
                        if (idx_q == len_m1_d) begin
                            state_q <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (byte_valid) begin
                        if (byte_data == xor_q) begin
                            state_q     <= S_DRAIN;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            idx_q       <= '0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= rd_data_d;
                            out_last_q  <= (len_q == IDX_ONE);
                        end else begin
                            chk_err_q <= 1'b1;
                            state_q   <= S_HUNT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (byte_valid) begin
                        ovr_err_q <= 1'b1;
                    end
                    if (out_valid_q && out_ready) begin
                        if (out_last_q) begin
                            state_q     <= S_HUNT;
                            out_valid_q <= 1'b0;
                            out_data_q  <= 8'h00;
                            out_last_q  <= 1'b0;
                        end else begin
                            idx_q      <= idx_inc_d;
                            out_data_q <= rd_data_d;
                            out_last_q <= (idx_inc_d == len_m1_d);
                        end
                    end
                end
                default: state_q <= S_HUNT;
            endcase
            if (to_expire_d) begin
                state_q <= S_HUNT;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign chk_err   = chk_err_q;
    assign len_err   = len_err_q;
    assign ovr_err   = ovr_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl: directed scenarios plus randomized frames
// checked against a frame-level reference model (expected payload queue,
// expected frame and error counts). Adapts the timeout scenario to whether
// UART_FRAME_TIMEOUT_EN is defined.
module tb_uart_rx_frame_ctrl;

    localparam int MAX_LEN = 16;
    localparam int TO      = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        chk_err;
    logic        len_err;
    logic        to_err;
    logic        ovr_err;
    logic [15:0] frame_cnt;

    uart_rx_frame_ctrl #(
        .HEADER        (8'hAA),
        .MAX_LEN       (MAX_LEN),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .chk_err   (chk_err),
        .len_err   (len_err),
        .to_err    (to_err),
        .ovr_err   (ovr_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_fc = 0;
    logic [7:0] pl [256];
    logic [8:0] got_q [$];
    int n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0;
    logic p_chk = 1'b0, p_len = 1'b0, p_to = 1'b0, p_ovr = 1'b0;
    bit rnd_en = 1'b0;

    // Monitor: record stream transfers and error pulses away from the clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) got_q.push_back({out_last, out_data});
            if (chk_err) n_chk++;
            if (len_err) n_len++;
            if (to_err)  n_to++;
            if (ovr_err) n_ovr++;
            if (chk_err || len_err || to_err || ovr_err) begin
                checks++;
                if ((chk_err && p_chk) || (len_err && p_len) || (to_err && p_to) || (ovr_err && p_ovr)) begin
                    errors++;
                    $display("FAIL pulse_width: error pulse high for 2+ cycles (chk%0b len%0b to%0b ovr%0b)",
                             chk_err, len_err, to_err, ovr_err);
                end
            end
        end
        p_chk = chk_err; p_len = len_err; p_to = to_err; p_ovr = ovr_err;
    end

    // Random downstream backpressure during the randomized scenario.
    always @(posedge clk) begin
        if (rnd_en) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gap(input int maxgap);
        if (maxgap > 0) idle($urandom_range(0, maxgap));
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic fill_pl(input int len);
        for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
    endtask

    task automatic send_frame(input int len, input bit corrupt, input int maxgap);
        logic [7:0] c;
        c = len[7:0];
        for (int i = 0; i < len; i++) c = c ^ pl[i];
        if (corrupt) c = c ^ 8'($urandom_range(1, 255));
        send_byte(8'hAA);
        gap(maxgap);
        send_byte(len[7:0]);
        gap(maxgap);
        for (int i = 0; i < len; i++) begin
            send_byte(pl[i]);
            gap(maxgap);
        end
        send_byte(c);
    endtask

    task automatic test_reset();
        rst = 1'b1; byte_valid = 1'b0; out_ready = 1'b0;
        idle(3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %0h exp 00", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b exp 0", out_last); end
        checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_fcnt got %0h exp 0", frame_cnt); end
        checks++; if ({chk_err, len_err, to_err, ovr_err} !== 4'b0) begin
            errors++; $display("FAIL reset_errs got %0b exp 0000", {chk_err, len_err, to_err, ovr_err});
        end
        rst = 1'b0;
        exp_fc = 0;
        idle(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %0b exp 0", out_valid); end
    endtask

    task automatic test_good_frame();
        int base, b_err;
        logic [8:0] exp [3];
        exp[0] = {1'b0, 8'h11}; exp[1] = {1'b0, 8'h22}; exp[2] = {1'b1, 8'h33};
        out_ready = 1'b1;
        base = got_q.size();
        b_err = n_chk + n_len + n_to + n_ovr;
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL good_early_valid got %0b exp 0", out_valid); end
        send_byte(8'h03);
        exp_fc++;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL good_valid_latency got %0b exp 1", out_valid); end
        checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL good_first_data got %0h exp 11", out_data); end
        checks++; if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL good_fcnt got %0d exp %0d", frame_cnt, exp_fc); end
        idle(5);
        checks++; if (got_q.size() - base != 3) begin errors++; $display("FAIL good_count got %0d exp 3", got_q.size() - base); end
        for (int i = 0; i < 3 && base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[base + i] !== exp[i]) begin errors++; $display("FAIL good_byte%0d got %0h exp %0h", i, got_q[base + i], exp[i]); end
        end
        checks++; if (n_chk + n_len + n_to + n_ovr != b_err) begin errors++; $display("FAIL good_no_err got %0d pulses exp 0", n_chk + n_len + n_to + n_ovr - b_err); end
    endtask

    task automatic test_bad_checksum();
        int base;
        out_ready = 1'b1;
        base = got_q.size();
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h31);
        checks++; if (chk_err !== 1'b1) begin errors++; $display("FAIL chk_err_pulse got %0b exp 1", chk_err); end
        idle(1);
        checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL chk_err_width got %0b exp 0", chk_err); end
        idle(3);
        checks++; if (got_q.size() != base) begin errors++; $display("FAIL chk_no_output got %0d bytes exp 0", got_q.size() - base); end
        checks++; if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL chk_fcnt got %0d exp %0d", frame_cnt, exp_fc); end
        fill_pl(2);
        send_frame(2, 1'b0, 0);
        exp_fc++;
        idle(4);
        checks++; if (got_q.size() - base != 2) begin errors++; $display("FAIL chk_recover_count got %0d exp 2", got_q.size() - base); end
        for (int i = 0; i < 2 && base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[base + i] !== {i == 1, pl[i]}) begin errors++; $display("FAIL chk_recover_byte%0d got %0h exp %0h", i, got_q[base + i], {i == 1, pl[i]}); end
        end
    endtask

    task automatic test_length_errors();
        int base, b_len;
        out_ready = 1'b1;
        base = got_q.size();
        b_len = n_len;
        send_byte(8'hAA); send_byte(8'h00);
        checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len_zero got %0b exp 1", len_err); end
        send_byte(8'hAA); send_byte(8'h11);
        checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len_over got %0b exp 1", len_err); end
        fill_pl(1);
        send_frame(1, 1'b0, 0);
        exp_fc++;
        checks++; if (out_valid !== 1'b1 || out_data !== pl[0] || out_last !== 1'b1) begin
            errors++; $display("FAIL len_recover got v%0b d%0h l%0b exp v1 d%0h l1", out_valid, out_data, out_last, pl[0]);
        end
        idle(3);
        checks++; if (n_len - b_len != 2) begin errors++; $display("FAIL len_pulse_count got %0d exp 2", n_len - b_len); end
        checks++; if (got_q.size() - base != 1) begin errors++; $display("FAIL len_recover_count got %0d exp 1", got_q.size() - base); end
    endtask

    task automatic test_overrun();
        int base, b_ovr;
        base = got_q.size();
        b_ovr = n_ovr;
        out_ready = 1'b0;
        fill_pl(4);
        send_frame(4, 1'b0, 0);
        exp_fc++;
        idle(5);
        send_byte(8'($urandom));
        checks++; if (ovr_err !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %0b exp 1", ovr_err); end
        idle(14);
        checks++; if (out_valid !== 1'b1 || out_data !== pl[0] || out_last !== 1'b0) begin
            errors++; $display("FAIL ovr_hold got v%0b d%0h l%0b exp v1 d%0h l0", out_valid, out_data, out_last, pl[0]);
        end
        out_ready = 1'b1;
        idle(6);
        checks++; if (got_q.size() - base != 4) begin errors++; $display("FAIL ovr_count got %0d exp 4", got_q.size() - base); end
        for (int i = 0; i < 4 && base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[base + i] !== {i == 3, pl[i]}) begin errors++; $display("FAIL ovr_byte%0d got %0h exp %0h", i, got_q[base + i], {i == 3, pl[i]}); end
        end
        checks++; if (n_ovr - b_ovr != 1) begin errors++; $display("FAIL ovr_pulse_count got %0d exp 1", n_ovr - b_ovr); end
        checks++; if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL ovr_fcnt got %0d exp %0d", frame_cnt, exp_fc); end
    endtask

    task automatic test_back_to_back();
        int base;
        logic [7:0] first;
        out_ready = 1'b1;
        base = got_q.size();
        fill_pl(1);
        first = pl[0];
        send_frame(1, 1'b0, 0);
        exp_fc++;
        idle(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_fall got %0b exp 0", out_valid); end
        fill_pl(2);
        send_frame(2, 1'b0, 0);
        exp_fc++;
        idle(4);
        checks++; if (got_q.size() - base != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", got_q.size() - base); end
        if (got_q.size() - base == 3) begin
            checks++;
            if (got_q[base] !== {1'b1, first} || got_q[base + 1] !== {1'b0, pl[0]} || got_q[base + 2] !== {1'b1, pl[1]}) begin
                errors++; $display("FAIL b2b_data got %0h %0h %0h exp %0h %0h %0h", got_q[base], got_q[base + 1], got_q[base + 2],
                                   {1'b1, first}, {1'b0, pl[0]}, {1'b1, pl[1]});
            end
        end
        checks++; if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL b2b_fcnt got %0d exp %0d", frame_cnt, exp_fc); end
    endtask

    task automatic test_timeout();
        int b_to;
        out_ready = 1'b1;
        b_to = n_to;
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
`ifdef UART_FRAME_TIMEOUT_EN
        begin
            int first;
            first = -1;
            for (int k = 1; k <= 120; k++) begin
                idle(1);
                if (to_err === 1'b1 && first < 0) first = k;
            end
            checks++; if (first != TO) begin errors++; $display("FAIL to_latency got %0d exp %0d", first, TO); end
            checks++; if (n_to - b_to != 1) begin errors++; $display("FAIL to_count got %0d exp 1", n_to - b_to); end
            send_byte(8'hAA); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
            exp_fc++;
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h7E || out_last !== 1'b1) begin
                errors++; $display("FAIL to_recover got v%0b d%0h l%0b exp v1 d7e l1", out_valid, out_data, out_last);
            end
        end
`else
        idle(150);
        checks++; if (n_to != b_to) begin errors++; $display("FAIL to_disabled got %0d pulses exp 0", n_to - b_to); end
        send_byte(8'h22); send_byte(8'h31);
        exp_fc++;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_last !== 1'b0) begin
            errors++; $display("FAIL stall_resume got v%0b d%0h l%0b exp v1 d11 l0", out_valid, out_data, out_last);
        end
`endif
        idle(3);
        checks++; if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL to_fcnt got %0d exp %0d", frame_cnt, exp_fc); end
    endtask

    task automatic test_reset_mid();
        int base;
        out_ready = 1'b1;
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_fc = 0;
        checks++; if ({out_valid, out_data, out_last, chk_err, len_err, to_err, ovr_err} !== 14'b0 || frame_cnt !== 16'h0) begin
            errors++; $display("FAIL rstmid_outputs got v%0b d%0h l%0b e%0b f%0d exp all 0", out_valid, out_data, out_last,
                               {chk_err, len_err, to_err, ovr_err}, frame_cnt);
        end
        base = got_q.size();
        fill_pl(3);
        send_frame(3, 1'b0, 0);
        exp_fc++;
        idle(5);
        checks++; if (got_q.size() - base != 3) begin errors++; $display("FAIL rstmid_count got %0d exp 3", got_q.size() - base); end
        for (int i = 0; i < 3 && base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[base + i] !== {i == 2, pl[i]}) begin errors++; $display("FAIL rstmid_byte%0d got %0h exp %0h", i, got_q[base + i], {i == 2, pl[i]}); end
        end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_fcnt got %0d exp 1", frame_cnt); end
        out_ready = 1'b0;
        fill_pl(2);
        send_frame(2, 1'b0, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_fc = 0;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || frame_cnt !== 16'h0) begin
            errors++; $display("FAIL rstdrain got v%0b d%0h f%0d exp v0 d00 f0", out_valid, out_data, frame_cnt);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_random();
        logic [8:0] exp_q [$];
        logic [7:0] b;
        int base, b_chk, b_len, b_ovr, b_to, e_chk, e_len, len, kind, w;
        base = got_q.size();
        b_chk = n_chk; b_len = n_len; b_ovr = n_ovr; b_to = n_to;
        e_chk = 0; e_len = 0;
        rnd_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hAA) b = 8'h55;
                send_byte(b);
                gap(2);
            end
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, MAX_LEN);
            fill_pl(len);
            if (kind == 8) begin
                send_byte(8'hAA);
                gap(2);
                b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
                send_byte(b);
                e_len++;
            end else if (kind == 7) begin
                send_frame(len, 1'b1, 2);
                e_chk++;
            end else begin
                send_frame(len, 1'b0, 2);
                for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, pl[i]});
                exp_fc++;
                w = 0;
                while (out_valid === 1'b1 && w < 400) begin
                    idle(1);
                    w++;
                end
                checks++;
                if (w >= 400) begin errors++; $display("FAIL rnd_drain_stuck frame %0d got valid after %0d cycles exp drained", f, w); end
            end
            gap(2);
        end
        rnd_en = 1'b0;
        idle(1);
        out_ready = 1'b1;
        idle(3);
        checks++; if (got_q.size() - base != exp_q.size()) begin
            errors++; $display("FAIL rnd_count got %0d exp %0d", got_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL rnd_byte%0d got %0h exp %0h", i, got_q[base + i], exp_q[i]); end
        end
        checks++; if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL rnd_fcnt got %0d exp %0d", frame_cnt, exp_fc); end
        checks++; if (n_chk - b_chk != e_chk) begin errors++; $display("FAIL rnd_chk_pulses got %0d exp %0d", n_chk - b_chk, e_chk); end
        checks++; if (n_len - b_len != e_len) begin errors++; $display("FAIL rnd_len_pulses got %0d exp %0d", n_len - b_len, e_len); end
        checks++; if (n_ovr - b_ovr != 0 || n_to - b_to != 0) begin
            errors++; $display("FAIL rnd_other_pulses got ovr %0d to %0d exp 0 0", n_ovr - b_ovr, n_to - b_to);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_length_errors();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

- Receive-side frame controller that sits directly behind the UART receiver.
- Consumes its one-cycle byte strobes, hunts for a header byte, and buffers one length-prefixed frame.
- Verifies the frame's XOR checksum, then replays the payload on a valid/ready stream to the downstream consumer.
- Flags malformed, late and overrun frames with one-cycle error pulses.

## Interface
Parameters:
- HEADER, 8'hAA, frame start byte
- MAX_LEN, 16, maximum payload length in bytes (1..255)
- TIMEOUT_CYCLES, 50000, inter-byte timeout in clk cycles (1 ms at 50 MHz)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- byte_valid  in  1  one-cycle strobe per received byte, from the UART receiver's ready output
- byte_data  in  8  received byte, valid when byte_valid=1
- out_valid  out  1  payload byte available
- out_data  out  8  payload byte
- out_last  out  1  marks the final payload byte of the frame
- out_ready  in  1  downstream accepts; a transfer happens when out_valid & out_ready
- chk_err  out  1  pulse: checksum mismatch
- len_err  out  1  pulse: LEN=0 or LEN>MAX_LEN
- to_err  out  1  pulse: inter-byte timeout
- ovr_err  out  1  pulse: byte dropped while draining
- frame_cnt  out  16  count of good frames, wraps at 16'hFFFF->0

## Operation
- Frame format: HEADER, LEN, LEN payload bytes, CHK.
- CHK is the XOR of LEN and all payload bytes.
- Payload is stored in an internal MAX_LEN x 8 buffer.
- States:
  - HUNT: non-HEADER bytes are ignored; HEADER -> LENGTH.
  - LENGTH: on a byte, LEN in 1..MAX_LEN -> store LEN, seed the running XOR with LEN, go to PAYLOAD. Otherwise pulse len_err and go to HUNT.
  - PAYLOAD: each byte is written to buf[idx], idx increments and XOR accumulates. After the LEN-th byte -> CHECK.
  - CHECK: on a byte, match -> DRAIN, frame_cnt+1, idx=0. Mismatch -> pulse chk_err, go to HUNT.
  - DRAIN: out_valid=1, out_data=buf[idx], out_last=(idx==LEN-1). Each transfer increments idx. A transfer with out_last -> HUNT.
- A HEADER value inside LEN/payload/CHK positions is treated as data; there is no resynchronisation mid-frame.
- A byte_valid in DRAIN is dropped and pulses ovr_err. Buffer contents and out_* are unaffected.
- Timeout (when compiled in):
  - Counter is active in LENGTH, PAYLOAD and CHECK, and cleared on every accepted byte and on entry to those states.
  - When the counter reaches TIMEOUT_CYCLES-1 with no byte that cycle: pulse to_err and go to HUNT.
  - A byte arriving in the expiry cycle wins and clears the counter.
- Widths:
  - idx and LEN are $clog2(MAX_LEN+1) bits.
  - Timeout counter is $clog2(TIMEOUT_CYCLES) bits, saturating logic not required.
- Reset:
  - State HUNT; idx, LEN, XOR and timeout counter cleared; frame_cnt=0.
  - All outputs 0, including out_data=8'h00.
  - Buffer contents are not reset.
  - Reset mid-frame or mid-drain abandons the frame with no error pulse.

## Timing
- Back-to-back byte_valid on consecutive cycles is accepted, one byte per cycle.
- State, XOR, idx and buffer writes are registered on the byte_valid cycle.
- out_valid rises the cycle after the CHK byte's strobe. frame_cnt updates on that same edge.
- The DRAIN stream sustains one byte per cycle while out_ready=1.
- out_data/out_last are stable while out_valid & !out_ready.
- out_valid falls the cycle after the last transfer. A HEADER strobe in that following cycle is accepted, since the state is HUNT.
- Error pulses are exactly one cycle wide, asserted the cycle after the offending strobe (or timeout expiry).
- Minimum latency from HEADER strobe to first out_valid: LEN+3 byte strobes + 1 cycle.

## Configuration
- UART_FRAME_TIMEOUT_EN defined: inter-byte timeout counter and to_err logic are present as described.
- UART_FRAME_TIMEOUT_EN undefined:
  - No counter is synthesised and to_err is tied to 0.
  - A stalled partial frame waits indefinitely until the remaining bytes arrive or rst is asserted.

## Test plan
- Good frame: strobes 0x55,0xAA,0x03,0x11,0x22,0x33,0x03 with out_ready=1 -> out stream 0x11,0x22,0x33; out_last only on 0x33; frame_cnt=1; no error pulses.
- Bad checksum: 0xAA,0x02,0x10,0x20,0x31 (expected 0x32) -> chk_err single pulse; out_valid never rises; frame_cnt unchanged. A following good frame is then received correctly.
- Length errors:
  - 0xAA,0x00 -> len_err.
  - 0xAA,0x11 with MAX_LEN=16 -> len_err.
  - Either way, the next byte 0xAA starts a new hunt successfully.
- Backpressure/overrun: good frame with LEN=4 and out_ready held 0 for 20 cycles, plus one byte_valid injected during DRAIN -> ovr_err pulse; out_data held at the first payload byte; all 4 bytes are then delivered once out_ready=1.
- Timeout (macro defined, TIMEOUT_CYCLES=100): 0xAA,0x02,0x11 then idle -> to_err exactly 100 cycles after the 0x11 strobe. Then 0xAA,0x01,0x7E,0x7F -> out_data 0x7E with out_last.
- Reset mid-frame: assert rst for 1 cycle after 0xAA,0x03,0x11 -> all outputs 0, frame_cnt=0. A subsequent full good frame is delivered.
